i2c_slave_regfile: RTL
======================

# i2c_slave_regfile

Parametrised I2C target that exposes a bank of `NUM_REGS` 8-bit registers to an I2C controller on the board bus. It supports:
- standard register-pointer writes and pointer-less reads;
- repeated-start combined transactions;
- pointer auto-increment with wrap;
- true open-drain SDA.

Register contents are presented as a flat vector to fabric logic, with a one-cycle write strobe for each committed byte. It is the successor to the fixed four-register target and sits between the board SDA/SCL pins and user logic.

## Interface
- `SLAVE_ADDR`, 7'h54, 7-bit target address.
- `NUM_REGS`, 8, register count; power of two, 2..256. `PTR_W = $clog2(NUM_REGS)`.
- `iClk`  in  1  system clock; all logic on posedge.
- `iRst_n`  in  1  reset, asynchronous, active-low.
- `iSCL`  in  1  bus clock (asynchronous to `iClk`).
- `ioSDA`  inout  1  bus data, open-drain: driven 0 or `'z` only, never driven 1.
- `oRegs`  out  `NUM_REGS*8`  register bank; reg k at bits `[8k+7:8k]`.
- `oWrValid`  out  1  one-cycle pulse per committed write byte.
- `oWrAddr`  out  `PTR_W`  index of the committed byte.
- `oWrData`  out  8  value of the committed byte.
- `oBusy`  out  1  high from detected START to detected STOP.

## Operation
- **Input sampling.** `iSCL` and SDA each pass through a 2-FF synchronizer, then a previous-value register. Edge, START and STOP detection use only the synchronized values.
  - START: SCL high and SDA 1→0.
  - STOP: SCL high and SDA 0→1.
- **START (including repeated start)** in any state:
  - enter `ADDR`, clear bit counter, release SDA, set `oBusy`;
  - the pointer is retained.
- **STOP** in any state: enter `IDLE`, release SDA, clear `oBusy`. The pointer is retained.
- **States:** `IDLE`, `ADDR`, `ADDR_ACK`, `PTR`, `PTR_ACK`, `WDATA`, `WDATA_ACK`, `RDATA`, `RDATA_ACK`.
- **`ADDR`:** shift 8 bits MSB-first on SCL rise; bits [7:1] are the address, bit 0 is R/W. After the 8th SCL fall, go to `ADDR_ACK`.
- **`ADDR_ACK`:**
  - On match: drive SDA 0 for the 9th clock.
  - On mismatch: keep SDA released and go to `IDLE` on the 9th SCL fall.
  - On match with W: go to `PTR`.
  - On match with R: load the tx shifter with `reg[ptr]` and go to `RDATA`.
- **`PTR`:** receive 8 bits. `ptr <= byte[PTR_W-1:0]` (upper bits ignored). Then go to `PTR_ACK`, which always ACKs and then goes to `WDATA`.
- **`WDATA`:** receive 8 bits. On the 8th SCL fall:
  - `reg[ptr] <= byte`;
  - `oWrValid=1` for one cycle with `oWrAddr=ptr`, `oWrData=byte`;
  - `ptr <= ptr+1` (modulo `NUM_REGS`);
  - go to `WDATA_ACK`, which ACKs and then returns to `WDATA`.
- **`RDATA`:**
  - Drive SDA 0 when the tx MSB is 0; release SDA when it is 1.
  - Shift the tx register left on each SCL fall.
  - After the 8th fall: `ptr <= ptr+1` (wrap), release SDA, go to `RDATA_ACK`.
- **`RDATA_ACK`:** sample SDA on SCL rise.
  - ACK (0): on SCL fall, load `reg[ptr]` and return to `RDATA`.
  - NACK (1): go to `IDLE` on SCL fall.
- **Aborted bytes.** A partial byte cut short by START/STOP is discarded: no register write and no pointer change.
- **General-call address (0x00)** is not acknowledged.
- **Arbitration and clock stretching** are not performed.

## Timing
- **Reset values:**
  - `oRegs` = 0; `oWrValid` = 0; `oWrAddr` = 0; `oWrData` = 0; `oBusy` = 0;
  - SDA released (`'z`); internal pointer = 0; state `IDLE`.
- **Reset mid-transaction:** SDA is released asynchronously and all state is cleared. The next transaction requires a fresh START.
- **Detection latency:** a pin edge is seen 3 `iClk` cycles after it occurs (2 sync stages plus the edge register).
- **SDA output updates** 1 cycle after a detected SCL fall. SDA output is registered; there is no combinational path from the pins to `ioSDA`.
- **Write commit:** `oRegs` updates in the same cycle that `oWrValid` is high, which is 1 cycle after the detected 8th SCL fall.
- **Clock requirement:** SCL low time ≥ 8 `iClk` periods, and SCL high time ≥ 4 `iClk` periods (e.g. 100 MHz `iClk` supports up to 1 MHz SCL).
- **Simultaneous SCL edge and START/STOP** in the same cycle: START/STOP wins.

## Test plan
- **Write with auto-increment.** `SLAVE_ADDR=0x54`, `NUM_REGS=8`. Send S, 0xA8, 0x02, 0x11, 0x22, P. Required: four ACKs; reg2=0x11 and reg3=0x22; two `oWrValid` pulses with (addr 2, 0x11) then (addr 3, 0x22); `oBusy` falls after P.
- **Combined read.** Continuing from the previous test, send S, 0xA8, 0x03, Sr, 0xA9, then read 2 bytes with ACK then NACK, then P. Required: bytes 0x22 then 0x00 (reg4); no `oWrValid`; SDA never driven high.
- **Wrap and pointer truncation.** Write S, 0xA8, 0x0F (ptr→7), 0xAA, 0xBB, P. Required: reg7=0xAA and reg0=0xBB. Then S, 0xA9, read 1 byte, NACK. Required: returns reg1.
- **Address mismatch.** Send S, 0xAA, then 8 more clocks, then P. Required: SDA released on every 9th clock; `oRegs` unchanged; `oBusy` high until P.
- **Abort.** Send S, 0xA8, 0x00, 4 data bits, P. Required: no `oWrValid`; reg0 unchanged; state `IDLE`; next read starts at ptr 0.
- **Reset mid-read.** Assert `iRst_n=0` while the target drives a 0 bit. Required: SDA `'z` immediately; all outputs at reset values; a subsequent S, 0xA9 read returns 0x00.

Source files
------------

// File: rtl/i2c_slave_regfile.sv
// rtl/i2c_slave_regfile.sv - I2C target exposing NUM_REGS 8-bit registers with pointer auto-increment
// SCL/SDA are synchronized and edge-detected in iClk; SDA is driven open-drain from a register.
module i2c_slave_regfile #(
    parameter logic [6:0] SLAVE_ADDR = 7'h54,
    parameter int         NUM_REGS   = 8,
    localparam int        PTR_W      = $clog2(NUM_REGS)
) (
    input  logic                  iClk,
    input  logic                  iRst_n,
    input  logic                  iSCL,
    inout  wire                   ioSDA,
    output logic [NUM_REGS*8-1:0] oRegs,
    output logic                  oWrValid,
    output logic [PTR_W-1:0]      oWrAddr,
    output logic [7:0]            oWrData,
    output logic                  oBusy
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
    } state_t;

    state_t                state_q, state_d;
    logic                  scl_s1_q, scl_s2_q, scl_prev_q;
    logic                  sda_s1_q, sda_s2_q, sda_prev_q;
    logic [3:0]            cnt_q, cnt_d;
    logic [7:0]            shift_q, shift_d;
    logic [7:0]            tx_q, tx_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic                  nack_q, nack_d;
    logic                  sda_oe_q, sda_oe_d;
    logic                  busy_q, busy_d;
    logic                  wr_valid_q, wr_valid_d;
    logic [PTR_W-1:0]      wr_addr_q, wr_addr_d;
    logic [7:0]            wr_data_q, wr_data_d;
    logic [NUM_REGS*8-1:0] regs_q, regs_d;

    logic       scl_rise, scl_fall, start_det, stop_det, addr_match;
    logic [7:0] rd_byte;

    assign scl_rise   = scl_s2_q & ~scl_prev_q;
    assign scl_fall   = ~scl_s2_q & scl_prev_q;
    assign start_det  = scl_s2_q & scl_prev_q & sda_prev_q & ~sda_s2_q;
    assign stop_det   = scl_s2_q & scl_prev_q & ~sda_prev_q & sda_s2_q;
    // General call (address 0) is never acknowledged, even if SLAVE_ADDR were 0.
    assign addr_match = (shift_q[7:1] == SLAVE_ADDR) && (shift_q[7:1] != 7'd0);
    assign rd_byte    = regs_q[{ptr_q, 3'b000} +: 8];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        ptr_d      = ptr_q;
        nack_d     = nack_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        regs_d     = regs_q;
        if (start_det) begin
            state_d  = ADDR;
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b1;
        end else if (stop_det) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                ADDR, PTR, WDATA: begin
                    if (scl_rise && cnt_q < 4'd8) begin
                        shift_d = {shift_q[6:0], sda_s2_q};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        sda_oe_d = 1'b1;
                        if (state_q == ADDR) begin
                            state_d  = ADDR_ACK;
                            sda_oe_d = addr_match;
                        end else if (state_q == PTR) begin
                            state_d = PTR_ACK;
                            ptr_d   = shift_q[PTR_W-1:0];
                        end else begin
                            state_d                       = WDATA_ACK;
                            regs_d[{ptr_q, 3'b000} +: 8]  = shift_q;
                            wr_valid_d                    = 1'b1;
                            wr_addr_d                     = ptr_q;
                            wr_data_d                     = shift_q;
                            ptr_d                         = ptr_q + PTR_W'(1);
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        cnt_d    = 4'd0;
                        sda_oe_d = 1'b0;
                        if (!addr_match) begin
                            state_d = IDLE;
                        end else if (shift_q[0]) begin
                            state_d  = RDATA;
                            tx_d     = rd_byte;
                            sda_oe_d = ~rd_byte[7];
                        end else begin
                            state_d = PTR;
                        end
                    end
                end
                PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        state_d  = WDATA;
                        cnt_d    = 4'd0;
                        sda_oe_d = 1'b0;
                    end
                end
                RDATA: begin
                    if (scl_fall) begin
                        if (cnt_q == 4'd7) begin
                            state_d  = RDATA_ACK;
                            sda_oe_d = 1'b0;
                            ptr_d    = ptr_q + PTR_W'(1);
                        end else begin
                            tx_d     = {tx_q[6:0], 1'b0};
                            sda_oe_d = ~tx_q[6];
                            cnt_d    = cnt_q + 4'd1;
                        end
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise) begin
                        nack_d = sda_s2_q;
                    end else if (scl_fall) begin
                        if (nack_q) begin
                            state_d = IDLE;
                        end else begin
                            state_d  = RDATA;
                            cnt_d    = 4'd0;
                            tx_d     = rd_byte;
                            sda_oe_d = ~rd_byte[7];
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            scl_s1_q   <= 1'b1;
            scl_s2_q   <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_s1_q   <= 1'b1;
            sda_s2_q   <= 1'b1;
            sda_prev_q <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            shift_q    <= 8'd0;
            tx_q       <= 8'd0;
            ptr_q      <= '0;
            nack_q     <= 1'b0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 8'd0;
            regs_q     <= '0;
        end else begin
            scl_s1_q   <= iSCL;
            scl_s2_q   <= scl_s1_q;
            scl_prev_q <= scl_s2_q;
            sda_s1_q   <= ioSDA;
            sda_s2_q   <= sda_s1_q;
            sda_prev_q <= sda_s2_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            ptr_q      <= ptr_d;
            nack_q     <= nack_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            regs_q     <= regs_d;
        end
    end

    assign ioSDA    = sda_oe_q ? 1'b0 : 1'bz;
    assign oRegs    = regs_q;
    assign oWrValid = wr_valid_q;
    assign oWrAddr  = wr_addr_q;
    assign oWrData  = wr_data_q;
    assign oBusy    = busy_q;

endmodule
